// File: rtl/obi_scratchpad_responder.sv
// OBI responder backed by a word-addressed scratchpad: configurable grant wait states,
// fixed read latency and a bounded in-order response queue.
package obi_scratchpad_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// Handshake: a transfer is accepted in any cycle where req and gnt are both 1; the response
// appears as a single-cycle rvalid exactly RD_LATENCY cycles later, in order, with no rready.
module obi_scratchpad_responder
  import obi_scratchpad_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 256,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hBADCAB1E
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  output logic      err_o
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int unsigned CD_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt;

  logic [31:0]      mem_q     [NUM_WORDS];
  logic [31:0]      q_rdata_q [MAX_OUTSTANDING];
  logic             q_err_q   [MAX_OUTSTANDING];
  logic [CD_W-1:0]  q_cd_q    [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;

  logic             in_range, accept, retire, slot_free;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      push_rdata;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^obi_req_i.addr[1:0];
  assign in_range  = ({2'b00, obi_req_i.addr[31:2]} < NUM_WORDS);
  assign word_idx  = obi_req_i.addr[IDX_W+1:2];
  assign retire    = (count_q != '0) && (q_cd_q[rd_ptr_q] == '0);
  assign slot_free = (count_q < OCC_W'(MAX_OUTSTANDING)) || retire;
  assign accept    = obi_req_i.req & gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (obi_req_i.req) begin
          if (GNT_WAIT == 0) begin
            gnt = slot_free;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        // A request withdrawn before its grant is abandoned; the next one waits afresh.
        if (!obi_req_i.req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if ((cnt_q >= CNT_W'(GNT_WAIT)) && slot_free) begin
          gnt     = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_W'(GNT_WAIT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) gnt = 1'b0;
  end

  // Scratchpad contents survive reset; only accepted in-range writes modify them.
  always_ff @(posedge clk_i) begin
    if (accept && obi_req_i.we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (obi_req_i.be[i]) mem_q[word_idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
      end
    end
  end

  assign push_rdata = obi_req_i.we ? 32'h0 : (in_range ? mem_q[word_idx] : ERR_RDATA);

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (q_cd_q[i] != '0) q_cd_q[i] <= q_cd_q[i] - CD_W'(1);
    end
    if (accept) begin
      q_rdata_q[wr_ptr_q] <= push_rdata;
      q_err_q[wr_ptr_q]   <= !in_range;
      q_cd_q[wr_ptr_q]    <= CD_W'(RD_LATENCY - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    obi_resp_o.gnt    = gnt;
    obi_resp_o.rvalid = retire;
    obi_resp_o.rdata  = retire ? q_rdata_q[rd_ptr_q] : 32'h0;
    err_o             = retire & q_err_q[rd_ptr_q];
  end

  logic [68:0] payload;
  assign payload = {obi_req_i.we, obi_req_i.be, obi_req_i.addr, obi_req_i.wdata};

  a_payload_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (obi_req_i.req && !gnt) |=> (!obi_req_i.req || $stable(payload)));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && !retire) |-> (count_q < OCC_W'(MAX_OUTSTANDING)));
  a_params: assert property (@(posedge clk_i) (RD_LATENCY >= 1) && (MAX_OUTSTANDING >= 1));

endmodule

// File: tb/tb_obi_scratchpad_responder.sv
// Bench for obi_scratchpad_responder: four instances cover default timing, grant wait
// states, outstanding-limit stalls and reset with responses in flight.
module tb_obi_scratchpad_responder;
  import obi_scratchpad_pkg::*;

  logic      clk = 1'b0;
  logic      rst, rst_d;
  obi_req_t  req_a, req_b, req_c, req_d;
  obi_resp_t resp_a, resp_b, resp_c, resp_d;
  logic      err_a, err_b, err_c, err_d;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_c_q[$];
  logic [32:0] exp_d_q[$];

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  obi_scratchpad_responder u_dut_a (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req_a), .obi_resp_o(resp_a), .err_o(err_a));
  obi_scratchpad_responder #(.GNT_WAIT(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req_b), .obi_resp_o(resp_b), .err_o(err_b));
  obi_scratchpad_responder #(.RD_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req_c), .obi_resp_o(resp_c), .err_o(err_c));
  obi_scratchpad_responder #(.RD_LATENCY(4), .MAX_OUTSTANDING(2)) u_dut_d (
    .clk_i(clk), .rst_i(rst_d), .obi_req_i(req_d), .obi_resp_o(resp_d), .err_o(err_d));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_spurious(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: rvalid with no response expected", name);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: every rvalid pops the oldest expected {err, rdata}.
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_a.rvalid === 1'b1) begin
      if (exp_a_q.size() == 0) fail_spurious("a_rvalid");
      else begin
        e = exp_a_q.pop_front();
        check("a_rdata", resp_a.rdata, e[31:0]);
        check("a_err", 32'(err_a), 32'(e[32]));
      end
    end
    if (resp_c.rvalid === 1'b1) begin
      if (exp_c_q.size() == 0) fail_spurious("c_rvalid");
      else begin
        e = exp_c_q.pop_front();
        check("c_rdata", resp_c.rdata, e[31:0]);
        check("c_err", 32'(err_c), 32'(e[32]));
      end
    end
    if (resp_d.rvalid === 1'b1) begin
      if (exp_d_q.size() == 0) fail_spurious("d_rvalid");
      else begin
        e = exp_d_q.pop_front();
        check("d_rdata", resp_d.rdata, e[31:0]);
        check("d_err", 32'(err_d), 32'(e[32]));
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    req_a = '{req: 1'b1, we: v.we, be: v.be, addr: v.addr, wdata: v.wdata};
    @(negedge clk);
    check($sformatf("v%0d_gnt", idx), 32'(resp_a.gnt), 32'd1);
    check($sformatf("v%0d_rvalid_at_gnt", idx), 32'(resp_a.rvalid), 32'd0);
    exp_a_q.push_back({v.exp_err, v.exp_rdata});
    next_cycle();
    req_a = '0;
    @(negedge clk);
    check($sformatf("v%0d_rvalid", idx), 32'(resp_a.rvalid), 32'd1);
    check($sformatf("v%0d_gnt_idle", idx), 32'(resp_a.gnt), 32'd0);
    next_cycle();
  endtask

  initial begin
    logic [15:0] rq_p, g_p, rv_p;
    logic [31:0] addr;

    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 4'h5, 32'h10,       32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 4'hF, 32'h0,        32'hCAFEF00D, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 4'hF, 32'h400,      32'h0,        32'hBADCAB1E, 1'b1};
    vecs[6]  = '{1'b1, 4'hF, 32'h400,      32'h5,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 4'hF, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 32'h13,       32'h0,        32'hDE22BE44, 1'b0};
    vecs[9]  = '{1'b1, 4'hF, 32'h3FC,      32'h12345678, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 4'hF, 32'h3FC,      32'h0,        32'h12345678, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,        32'hBADCAB1E, 1'b1};
    vecs[12] = '{1'b1, 4'h8, 32'h3FC,      32'hAA000000, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 4'hF, 32'h3FC,      32'h0,        32'hAA345678, 1'b0};

    rst = 1'b1; rst_d = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst_d = 1'b0;
    @(negedge clk);
    check("rst_a_gnt", 32'(resp_a.gnt), 32'd0);
    check("rst_a_rvalid", 32'(resp_a.rvalid), 32'd0);
    check("rst_a_rdata", resp_a.rdata, 32'd0);
    check("rst_a_err", 32'(err_a), 32'd0);
    check("rst_d_rvalid", 32'(resp_d.rvalid), 32'd0);
    next_cycle();

    // Default timing, byte enables, out-of-range accesses.
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Grant wait states: held request, back-to-back request, withdrawn request.
    rq_p = 16'h7BFF; g_p = 16'h4088; rv_p = 16'h8110;
    req_b = '{req: 1'b0, we: 1'b1, be: 4'hF, addr: 32'h20, wdata: 32'h5A5A5A5A};
    for (int c = 0; c < 16; c++) begin
      req_b.req = rq_p[c];
      @(negedge clk);
      check($sformatf("b_c%0d_gnt", c), 32'(resp_b.gnt), 32'(g_p[c]));
      check($sformatf("b_c%0d_rvalid", c), 32'(resp_b.rvalid), 32'(rv_p[c]));
      check($sformatf("b_c%0d_rdata", c), resp_b.rdata, 32'd0);
      next_cycle();
    end
    req_b = '0;

    // Outstanding limit: third back-to-back read stalls until the first retires.
    for (int i = 0; i < 3; i++) begin
      req_c = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'(i * 4), wdata: 32'h11110000 + 32'(i)};
      exp_c_q.push_back(33'h0);
      next_cycle();
      req_c = '0;
      repeat (3) next_cycle();
    end
    g_p = 16'h000B; rv_p = 16'h0058;
    for (int c = 0; c < 8; c++) begin
      addr = (c < 2) ? 32'(c * 4) : 32'h8;
      if (c < 4) req_c = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: addr, wdata: 32'h0};
      else req_c = '0;
      @(negedge clk);
      check($sformatf("c_c%0d_gnt", c), 32'(resp_c.gnt), 32'(g_p[c]));
      check($sformatf("c_c%0d_rvalid", c), 32'(resp_c.rvalid), 32'(rv_p[c]));
      if (g_p[c]) exp_c_q.push_back({1'b0, 32'h11110000 + (addr >> 2)});
      next_cycle();
    end
    req_c = '0;

    // Reset with two reads in flight: responses dropped, memory retained.
    req_d = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h8, wdata: 32'h600D600D};
    exp_d_q.push_back(33'h0);
    next_cycle();
    req_d = '0;
    repeat (4) next_cycle();
    req_d = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h8, wdata: 32'h0};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("d_rd%0d_gnt", c), 32'(resp_d.gnt), 32'd1);
      next_cycle();
    end
    req_d = '0;
    rst_d = 1'b1;
    @(negedge clk);
    check("d_gnt_in_rst", 32'(resp_d.gnt), 32'd0);
    next_cycle();
    rst_d = 1'b0;
    for (int c = 3; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("d_c%0d_rvalid", c), 32'(resp_d.rvalid), 32'd0);
      check($sformatf("d_c%0d_rdata", c), resp_d.rdata, 32'd0);
      next_cycle();
    end
    req_d = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h8, wdata: 32'h0};
    @(negedge clk);
    check("d_post_rst_gnt", 32'(resp_d.gnt), 32'd1);
    exp_d_q.push_back({1'b0, 32'h600D600D});
    next_cycle();
    req_d = '0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("d_post_rst_rvalid_%0d", c), 32'(resp_d.rvalid), 32'(c == 4));
      next_cycle();
    end

    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("c_queue_drained", 32'(exp_c_q.size()), 32'd0);
    check("d_queue_drained", 32'(exp_d_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
